// File: rtl/shift_normalize.sv
// shift_normalize: iterative CLZ/CLO normaliser returning leading count and left-normalised operand
module shift_normalize #(
  parameter int REG_WIDTH = 32,
  parameter int CNT_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 mode,
  input  logic [REG_WIDTH-1:0] data_in,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_WIDTH-1:0] count,
  output logic [REG_WIDTH-1:0] result,
  output logic                 all_flag
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t                 state;
  logic [REG_WIDTH-1:0]   shreg;
  logic [CNT_WIDTH-1:0]   cnt;
  logic                   tgt;
  logic                   full;
  assign full     = cnt == CNT_WIDTH'(REG_WIDTH);
  assign in_ready = rst_n && state == IDLE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      tgt       <= 1'b0;
      out_valid <= 1'b0;
      count     <= '0;
      result    <= '0;
      all_flag  <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          shreg <= data_in;
          tgt   <= mode;
          cnt   <= '0;
          state <= SHIFT;
        end
        SHIFT: if (full || shreg[REG_WIDTH-1] != tgt) begin
          state     <= DONE;
          out_valid <= 1'b1;
          count     <= cnt;
          result    <= shreg;
          all_flag  <= full;
        end else begin
          shreg <= {shreg[REG_WIDTH-2:0], 1'b0};
          cnt   <= cnt + CNT_WIDTH'(1);
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
